matmul_engine: RTL and testbench

- Handshaked, parametrised NxN matrix multiplier. Computes C = A x B, or C = C + A x B when accumulating.
- Time-multiplexes the k (inner-product) dimension: an N*N array of multiply-accumulate units consumes one k index per cycle.
- Lossless-width accumulators, a signed/unsigned mode and tile accumulation support blocked multiplies of larger matrices.
- Sits between the operand buffers and the result writeback path in the linear-algebra datapath.

---
 rtl/matmul_engine.sv | 161 ++++++++++++++++
 tb/tb_matmul_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_engine.sv
// matmul_engine: handshaked NxN matrix multiplier, C = A x B or C += A x B, one inner-product index per cycle.
// Optional: define MATMUL_SATURATE_EN to saturate the accumulator-to-c narrowing and add the sat_flag output.
module matmul_engine #(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int SIGNED    = 0,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(N) + 4,
  parameter int OUT_WIDTH = 2*WIDTH + $clog2(N)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_acc,
  input  logic [N-1:0][N-1:0][WIDTH-1:0]        a,
  input  logic [N-1:0][N-1:0][WIDTH-1:0]        b,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [N-1:0][N-1:0][OUT_WIDTH-1:0]    c,
  output logic                                  busy
`ifdef MATMUL_SATURATE_EN
  ,
  output logic                                  sat_flag
`endif
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_OUT
  } state_t;

  state_t                                 r_state;
  logic [N-1:0][N-1:0][WIDTH-1:0]         r_a;
  logic [N-1:0][N-1:0][WIDTH-1:0]         r_b;
  logic [N-1:0][N-1:0][ACC_WIDTH-1:0]     r_acc;
  logic [N-1:0][N-1:0][OUT_WIDTH-1:0]     r_c;
  logic [KW-1:0]                          r_k;
  logic                                   r_out_valid;

  logic [N-1:0][N-1:0][ACC_WIDTH-1:0]     w_acc_next;
  logic [N-1:0][N-1:0][OUT_WIDTH-1:0]     w_c_next;
  logic                                   w_k_last;

  // Widen an operand to accumulator width so products and sums never lose bits.
  function automatic logic [ACC_WIDTH-1:0] ext(input logic [WIDTH-1:0] x);
    if (SIGNED != 0) return {{(ACC_WIDTH-WIDTH){x[WIDTH-1]}}, x};
    else             return {{(ACC_WIDTH-WIDTH){1'b0}}, x};
  endfunction

  assign w_k_last = (r_k == KW'(N-1));

  // NOTE: every always_comb output is assigned on every path (loop covers all elements), so no latches.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_acc_next[i][j] = r_acc[i][j] + ext(r_a[i][r_k]) * ext(r_b[r_k][j]);
      end
    end
  end

`ifdef MATMUL_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] UMAX = (ACC_WIDTH'(1) << OUT_WIDTH) - ACC_WIDTH'(1);
  localparam logic [ACC_WIDTH-1:0] SMAX = (ACC_WIDTH'(1) << (OUT_WIDTH-1)) - ACC_WIDTH'(1);
  localparam logic [ACC_WIDTH-1:0] SMIN = ~SMAX;

  logic w_sat_any;
  logic r_sat_flag;

  always_comb begin
    w_sat_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_c_next[i][j] = w_acc_next[i][j][OUT_WIDTH-1:0];
        if (SIGNED != 0) begin
          if ($signed(w_acc_next[i][j]) > $signed(SMAX)) begin
            w_c_next[i][j] = SMAX[OUT_WIDTH-1:0];
            w_sat_any      = 1'b1;
          end else if ($signed(w_acc_next[i][j]) < $signed(SMIN)) begin
            w_c_next[i][j] = SMIN[OUT_WIDTH-1:0];
            w_sat_any      = 1'b1;
          end
        end else if (w_acc_next[i][j] > UMAX) begin
          w_c_next[i][j] = UMAX[OUT_WIDTH-1:0];
          w_sat_any      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_flag <= 1'b0;
    end else if (r_state == S_COMPUTE && w_k_last) begin
      r_sat_flag <= w_sat_any;
    end
  end

  assign sat_flag = r_sat_flag;
`else
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_c_next[i][j] = w_acc_next[i][j][OUT_WIDTH-1:0];
      end
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      // NOTE: the accumulator array is reset on purpose; a later in_acc=1 must not see stale sums.
      r_acc       <= '0;
      r_c         <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_k     <= '0;
            r_state <= S_COMPUTE;
            if (!in_acc) r_acc <= '0;
          end
        end
        S_COMPUTE: begin
          r_acc <= w_acc_next;
          if (w_k_last) begin
            r_c         <= w_c_next;
            r_k         <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_COMPUTE);
  assign out_valid = r_out_valid;
  assign c         = r_c;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed self-checking bench for matmul_engine: unsigned, signed, tiling, backpressure, reset abort, narrowing.
module tb_matmul_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for the three N=2, WIDTH=8 instances.
  logic                   iv2, acc2, ordy2;
  logic [1:0][1:0][7:0]   a2, b2;
  logic                   ir0, ov0, bz0;
  logic [1:0][1:0][16:0]  c0;
  logic                   ir1, ov1, bz1;
  logic [1:0][1:0][16:0]  c1;
  logic                   ir3, ov3, bz3;
  logic [1:0][1:0][7:0]   c3;

  // N=4 instance.
  logic                   iv4, acc4, ordy4;
  logic [3:0][3:0][7:0]   a4, b4;
  logic                   ir2, ov2, bz2;
  logic [3:0][3:0][17:0]  c2;

`ifdef MATMUL_SATURATE_EN
  logic sat0, sat1, sat2, sat3;
`endif

  matmul_engine #(.N(2), .WIDTH(8), .SIGNED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir0), .in_acc(acc2),
    .a(a2), .b(b2), .out_valid(ov0), .out_ready(ordy2), .c(c0), .busy(bz0)
`ifdef MATMUL_SATURATE_EN
    , .sat_flag(sat0)
`endif
  );

  matmul_engine #(.N(2), .WIDTH(8), .SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir1), .in_acc(acc2),
    .a(a2), .b(b2), .out_valid(ov1), .out_ready(ordy2), .c(c1), .busy(bz1)
`ifdef MATMUL_SATURATE_EN
    , .sat_flag(sat1)
`endif
  );

  matmul_engine #(.N(2), .WIDTH(8), .SIGNED(1), .OUT_WIDTH(8)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir3), .in_acc(acc2),
    .a(a2), .b(b2), .out_valid(ov3), .out_ready(ordy2), .c(c3), .busy(bz3)
`ifdef MATMUL_SATURATE_EN
    , .sat_flag(sat3)
`endif
  );

  matmul_engine #(.N(4), .WIDTH(8), .SIGNED(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir2), .in_acc(acc4),
    .a(a4), .b(b4), .out_valid(ov2), .out_ready(ordy4), .c(c2), .busy(bz2)
`ifdef MATMUL_SATURATE_EN
    , .sat_flag(sat2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input int a00, a01, a10, a11, b00, b01, b10, b11);
    a2[0][0] = 8'(a00); a2[0][1] = 8'(a01); a2[1][0] = 8'(a10); a2[1][1] = 8'(a11);
    b2[0][0] = 8'(b00); b2[0][1] = 8'(b01); b2[1][0] = 8'(b10); b2[1][1] = 8'(b11);
  endtask

  // Accept one operation on the N=2 instances, scramble operands, wait until OUT.
  task automatic do_op2(input logic acc);
    iv2  = 1'b1;
    acc2 = acc;
    tick();
    iv2 = 1'b0;
    a2  = {4{8'h5A}};
    b2  = {4{8'hC3}};
    tick();
    tick();
  endtask

  function automatic logic [67:0] m17(input int c00, c01, c10, c11);
    logic [1:0][1:0][16:0] m;
    m[0][0] = 17'(c00); m[0][1] = 17'(c01); m[1][0] = 17'(c10); m[1][1] = 17'(c11);
    return m;
  endfunction

  logic [67:0]           exp_base;
  logic [3:0][3:0][17:0] e4;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    iv2 = 1'b0; acc2 = 1'b0; ordy2 = 1'b1; a2 = '0; b2 = '0;
    iv4 = 1'b0; acc4 = 1'b0; ordy4 = 1'b1; a4 = '0; b4 = '0;
    exp_base = m17(19, 22, 43, 50);
    #1 rst_n = 1'b0;
    #9;
    check("reset_out_valid", ov0, 1'b0);
    check("reset_c", c0, '0);
    check("reset_in_ready", ir0, 1'b1);
    check("reset_busy", bz0, 1'b0);
    #2 rst_n = 1'b1;
    tick();

    // Basic unsigned with latency/handshake timing.
    set2(1, 2, 3, 4, 5, 6, 7, 8);
    iv2 = 1'b1; acc2 = 1'b0; ordy2 = 1'b1;
    tick();
    iv2 = 1'b0; a2 = {4{8'hFF}}; b2 = {4{8'hFF}};
    check("basic_in_ready_t0", ir0, 1'b0);
    check("basic_busy_t0", bz0, 1'b1);
    check("basic_out_valid_t0", ov0, 1'b0);
    tick();
    check("basic_out_valid_t1", ov0, 1'b0);
    check("basic_busy_t1", bz0, 1'b1);
    tick();
    check("basic_out_valid_t2", ov0, 1'b1);
    check("basic_c", c0, exp_base);
    check("basic_in_ready_out", ir0, 1'b0);
    check("basic_busy_out", bz0, 1'b0);
`ifdef MATMUL_SATURATE_EN
    check("basic_no_sat", sat3, 1'b0);
`endif
    tick();
    check("basic_out_valid_drop", ov0, 1'b0);
    check("basic_in_ready_back", ir0, 1'b1);

    // Tile accumulate, then clear again.
    set2(1, 2, 3, 4, 5, 6, 7, 8);
    do_op2(1'b1);
    check("tile_out_valid", ov0, 1'b1);
    check("tile_c_acc", c0, m17(38, 44, 86, 100));
    tick();
    set2(1, 2, 3, 4, 5, 6, 7, 8);
    do_op2(1'b0);
    check("tile_c_clear", c0, exp_base);
    tick();

    // Backpressure: hold OUT for 10 cycles while upstream pushes.
    ordy2 = 1'b0;
    set2(1, 2, 3, 4, 5, 6, 7, 8);
    do_op2(1'b0);
    check("bp_out_valid_enter", ov0, 1'b1);
    iv2 = 1'b1; acc2 = 1'b1;
    set2(9, 9, 9, 9, 9, 9, 9, 9);
    for (int n = 0; n < 10; n++) begin
      tick();
      check("bp_out_valid_hold", ov0, 1'b1);
      check("bp_c_stable", c0, exp_base);
      check("bp_in_ready_low", ir0, 1'b0);
    end
    iv2 = 1'b0; acc2 = 1'b0; ordy2 = 1'b1;
    tick();
    check("bp_release_out_valid", ov0, 1'b0);
    check("bp_release_in_ready", ir0, 1'b1);
    tick();
    check("bp_single_handshake", ov0, 1'b0);
    check("bp_no_accept", bz0, 1'b0);

    // Signed products.
    set2(-1, 2, 3, -4, 5, -6, 7, 8);
    do_op2(1'b0);
    check("signed_out_valid", ov1, 1'b1);
    check("signed_c", c1, m17(9, 22, -13, -50));
    tick();

    // Narrowing to 8 bits on the signed instance: 2*127*127 = 32258.
    set2(127, 127, 127, 127, 127, 127, 127, 127);
    do_op2(1'b0);
    check("narrow_out_valid", ov3, 1'b1);
`ifdef MATMUL_SATURATE_EN
    check("narrow_c_sat", c3, {4{8'd127}});
    check("narrow_sat_flag", sat3, 1'b1);
`else
    check("narrow_c_wrap", c3, {4{8'd2}});
`endif
    tick();

    // N=4: full op, then reset at k=2 of an accumulating op.
    a4 = {16{8'd1}}; b4 = {16{8'd1}};
    iv4 = 1'b1; acc4 = 1'b0; ordy4 = 1'b1;
    tick();
    iv4 = 1'b0;
    tick(); tick(); tick();
    check("n4_out_valid_t3", ov2, 1'b0);
    tick();
    check("n4_out_valid_t4", ov2, 1'b1);
    check("n4_c_ones", c2, {16{18'd4}});
    tick();
    a4 = {16{8'd2}}; b4 = {16{8'd2}};
    iv4 = 1'b1; acc4 = 1'b1;
    tick();
    iv4 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", ov2, 1'b0);
    check("rst_mid_c", c2, '0);
    check("rst_mid_busy", bz2, 1'b0);
    check("rst_mid_in_ready", ir2, 1'b1);
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a4[i][j] = (i == j) ? 8'd1 : 8'd0;
        b4[i][j] = (i == j) ? 8'd1 : 8'd0;
        e4[i][j] = (i == j) ? 18'd1 : 18'd0;
      end
    iv4 = 1'b1; acc4 = 1'b1;
    tick();
    iv4 = 1'b0; a4 = '1; b4 = '1;
    tick(); tick(); tick(); tick();
    check("ident_out_valid", ov2, 1'b1);
    check("ident_c", c2, e4);
    tick();
    check("ident_out_valid_drop", ov2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
